// File: rtl/if_id_queue_if.sv
// IF/ID queue bundle: fetch-side push, decode-side pop, flush and occupancy.
// master = pipeline environment driving the queue, slave = the queue itself.
// Optional perf outputs exist only when IF_ID_PERF_EN is defined.
interface if_id_queue_if #(
  parameter int IW_W  = 16,
  parameter int PC_W  = 16,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic [IW_W-1:0]  in_iw;
  logic [PC_W-1:0]  in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [IW_W-1:0]  out_iw;
  logic [PC_W-1:0]  out_pc;
  logic             out_ready;
  logic [CNT_W-1:0] count;
`ifdef IF_ID_PERF_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      bubble_cycles;

  modport master (
    output flush, in_valid, in_iw, in_pc, out_ready,
    input  in_ready, out_valid, out_iw, out_pc, count, stall_cycles, bubble_cycles
  );
  modport slave (
    input  flush, in_valid, in_iw, in_pc, out_ready,
    output in_ready, out_valid, out_iw, out_pc, count, stall_cycles, bubble_cycles
  );
`else
  modport master (
    output flush, in_valid, in_iw, in_pc, out_ready,
    input  in_ready, out_valid, out_iw, out_pc, count
  );
  modport slave (
    input  flush, in_valid, in_iw, in_pc, out_ready,
    output in_ready, out_valid, out_iw, out_pc, count
  );
`endif
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer between fetch and decode, NOP toward decode when empty.
// Latency: one falling edge from push to visibility at the head; no same-cycle bypass.
// Backpressure: in_ready depends on occupancy only (full refuses a push even with a coincident pop).
// Optional macro IF_ID_PERF_EN adds saturating stall_cycles / bubble_cycles counters.
module if_id_queue #(
  parameter int              IW_W   = 16,
  parameter int              PC_W   = 16,
  parameter int              DEPTH  = 2,
  parameter logic [IW_W-1:0] NOP_IW = IW_W'(16'hfffe)
) (
  input  logic          clk,
  input  logic          resetn,
  if_id_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IW_W-1:0] iw;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_last_pc;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rp];
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = ~w_empty & bus.out_ready;

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_iw    = w_empty ? NOP_IW : w_head.iw;
  assign bus.out_pc    = w_empty ? r_last_pc : w_head.pc;
  assign bus.count     = r_count;

  // Storage write; contents are don't-care after reset/flush, so no reset here.
  always_ff @(negedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= '{iw: bus.in_iw, pc: bus.in_pc};
    end
  end

  // Pointers and occupancy: reset beats flush, flush discards any same-cycle push/pop.
  always_ff @(negedge clk) begin
    if (!resetn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember the PC of the last popped entry, even when the pop coincides with a flush.
  always_ff @(negedge clk) begin
    if (!resetn) begin
      r_last_pc <= '0;
    end else if (w_pop) begin
      r_last_pc <= w_head.pc;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_cycles;

  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.bubble_cycles = r_bubble_cycles;

  // Saturating counters of decode stalls and empty-queue bubbles; flush does not clear them.
  always_ff @(negedge clk) begin
    if (!resetn) begin
      r_stall_cycles  <= '0;
      r_bubble_cycles <= '0;
    end else begin
      if (~w_empty & ~bus.out_ready & (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_empty & ~bus.flush & (r_bubble_cycles != '1)) begin
        r_bubble_cycles <= r_bubble_cycles + 32'd1;
      end
    end
  end
`endif
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID pipeline boundary. It replaces the single-entry fetch/decode register with a DEPTH-entry instruction queue, so fetch keeps running while decode stalls. It provides a valid/ready handshake on both sides, a flush that discards all queued instructions, and NOP insertion toward decode whenever the queue is empty. It sits between the fetch stage (PC + instruction memory) and the decode stage.

## Interface
Parameters:
- IW_W, 16, instruction word width
- PC_W, 16, program counter width
- DEPTH, 2, queue entries; power of two, ≥2
- NOP_IW, 16'hfffe, word presented to decode when no instruction is valid; width IW_W

Ports:
- clk  input  1  clock; all state updates on the falling edge, consistent with the other pipeline registers
- resetn  input  1  reset, synchronous, active-low
- flush  input  1  discard all queued entries (branch/jump redirect)
- in_valid  input  1  fetch presents an instruction
- in_iw  input  IW_W  fetched instruction word
- in_pc  input  PC_W  PC of in_iw
- in_ready  output  1  queue can accept a push
- out_valid  output  1  head entry valid toward decode
- out_iw  output  IW_W  head instruction, or NOP_IW when empty
- out_pc  output  PC_W  head PC, or last popped PC when empty
- out_ready  input  1  decode accepts the head (low = decode stall)
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of {iw, pc}, write pointer wp, read pointer rp, occupancy count.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is a function of state only and has no combinational path from out_ready. A full queue therefore does not accept a push even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_iw = mem[rp] when out_valid, else NOP_IW.
- out_pc = mem[rp].pc when out_valid, else last_pc.
- last_pc register: updated with mem[rp].pc on every pop.
- push only: write mem[wp], wp+1 mod DEPTH, count+1.
- pop only: rp+1 mod DEPTH, count−1.
- push & pop together (count in 1..DEPTH−1): both pointers advance, count unchanged.
- Push into an empty queue: entry is visible at the output one falling edge later. There is no same-cycle bypass.
- Pointer wrap: natural modulo DEPTH; no pointer ever skips or stalls at the wrap.
- flush=1: next edge sets wp=rp=0 and count=0. A push or pop in the same cycle is discarded. last_pc is updated if a pop coincided with the flush.
- Priority: resetn low > flush > push/pop.

## Timing
- Reset values (resetn low at an edge): wp=rp=count=0, last_pc=0. Outputs become out_valid=0, out_iw=NOP_IW, out_pc=0, in_ready=1, count=0.
- Reset asserted mid-operation discards all entries in one edge. Contents of mem are don't-care after reset.
- Latency in→out: 1 edge.
- Throughput: 1 instruction/cycle sustained while count < DEPTH and decode is ready.
- Flush recovery: in_ready=1 and out_valid=0 on the first cycle after the flush edge.
- All outputs are combinational from registered state only.

## Configuration
- IF_ID_PERF_EN defined: adds outputs stall_cycles[31:0] and bubble_cycles[31:0].
  - stall_cycles increments each edge with out_valid & ~out_ready.
  - bubble_cycles increments each edge with ~out_valid & ~flush.
  - Both saturate at 32'hffffffff, clear on reset, and are unaffected by flush.
- IF_ID_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset: resetn low 2 cycles → out_valid=0, out_iw=16'hfffe, out_pc=0, count=0, in_ready=1.
- Streaming: push PC 0x0010..0x0013 with out_ready=1 → each word appears 1 edge after push, count stays ≤1, no bubbles after the first.
- Fill and stall, DEPTH=2: out_ready=0, push 0x1111@0x20, then 0x2222@0x22 → count=2, in_ready=0, third word refused. Raise out_ready → pops in order 0x1111, 0x2222. Then out_iw=0xfffe and out_pc=0x22.
- Wrap: DEPTH=4, 10 pushes with pops interleaved randomly → output order equals input order and count never exceeds 4.
- Flush with simultaneous push: count=2, assert flush together with in_valid (0x3333) → next cycle count=0, out_valid=0, 0x3333 never appears at the output.
- IF_ID_PERF_EN: 5 stalled cycles, then 3 empty cycles → stall_cycles=5, bubble_cycles=3. Flush leaves both unchanged.
